pe3_seq: RTL and testbench
==========================

# pe3_seq

Sequencer that drives one pass of PE3 butterflies over an in-place coefficient memory. It issues paired read addresses (u at index j, v at j+N_PAIRS), presents the twiddle select aligned with the returned data, and tracks PE3's fixed pipeline latency with a valid/address delay line. It writes both butterfly outputs back to the source addresses. It sits between the NTT top-level controller (start/done) and the PE3 datapath plus its two-port coefficient RAM.

## Interface
Parameters:
- data_width, 12, coefficient width; only used for pass-through checks, since data never enters this block.
- addr_width, 7, coefficient RAM address width.
- N_PAIRS, 64, butterflies per pass; must be at most 2^(addr_width-1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the last write.
- done  out  1  one-cycle pulse after the last write.
- rd_en  out  1  read strobe to the coefficient RAM (both ports).
- rd_addr_u  out  addr_width  u read address (j).
- rd_addr_v  out  addr_width  v read address (j+N_PAIRS).
- sel  out  1  PE3 twiddle select, aligned with RAM read data (one cycle after rd_en).
- wr_en  out  1  write strobe for both PE3 outputs.
- wr_addr_u  out  addr_width  address for bf_upper; equals the u read address of the same pair.
- wr_addr_v  out  addr_width  address for bf_lower; equals the v read address of the same pair.

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE when start=1. Counter j is cleared to 0.
- In ISSUE, rd_en=1 every cycle with rd_addr_u=j and rd_addr_v=j+N_PAIRS. j increments each cycle. After j=N_PAIRS-1 is issued, the FSM moves to DRAIN.
- DRAIN holds until the delay line holds no valid entry. It then moves to DONE.
- DONE lasts one cycle with done=1, then returns to IDLE.
- The pass has no stall or back-pressure. PE3 has no enable, so issue is unconditional.
- sel is 0 for j < N_PAIRS/2 (twiddle 2285) and 1 otherwise (twiddle 3095). The value is registered one cycle after rd_en so it matches the RAM read data.
- The delay line carries {valid, addr_u, addr_v} for RAM_RD_LAT + PE3_LAT = 7 cycles. Its output drives wr_en and the write addresses.
- Address arithmetic is unsigned, modulo 2^addr_width. With legal N_PAIRS, j+N_PAIRS never wraps.
- start is ignored while busy or in DONE. It is not queued.
- rst asserted at any time, including mid-pass, forces IDLE, clears j, and clears all delay-line valid bits. This causes no spurious writes after reset. Outputs return to reset values immediately.

## Timing
- Reset values: busy=0, done=0, rd_en=0, sel=0, wr_en=0, all addresses=0.
- Let start be sampled high at edge E0. rd_en is high in cycles 1..N_PAIRS after E0. The read for pair j occurs in cycle 1+j.
- The RAM returns data in cycle 2+j, and sel for pair j is valid in that same cycle.
- PE3 output for pair j is valid in cycle 8+j, where wr_en=1 with wr_addr_u=j and wr_addr_v=j+N_PAIRS.
- busy is high in cycles 1..N_PAIRS+7. done is high in cycle N_PAIRS+8. The FSM is back in IDLE in cycle N_PAIRS+9.
- A start in the same cycle as done is ignored. The earliest accepted restart is in cycle N_PAIRS+9.
- Total pass latency is N_PAIRS+8 cycles from start to done.

## Structure
- Shared package pe3_pkg holds:
  - PE3_LAT=6 and RAM_RD_LAT=1;
  - TW_SEL0=2285 and TW_SEL1=3095, for documentation and the bench golden model;
  - the state enum typedef (IDLE/ISSUE/DRAIN/DONE).
- One sub-module, pe3_delay_line: a parameterised-depth, parameterised-width shift register with an asynchronous active-high clear. It is instantiated once for {valid, addr_u, addr_v} (depth 7) and once for sel (depth 1).

## Test plan
- Reset, then start with N_PAIRS=64:
  - rd_en is high in cycles 1..64, with rd_addr_u 0..63 and rd_addr_v 64..127;
  - wr_en is high in cycles 8..71 with matching addresses;
  - done is high in cycle 72 only.
- Check sel alignment: sel=0 in cycles 2..33 and sel=1 in cycles 34..65.
- End-to-end with the real PE3 and the RAM model: the memory after the pass equals the golden butterfly mod 3329, u' = u+v·w and v' = u−v·w with w per sel. A sample case is u=1 and v=1 at j=0, where w=2285, which gives u'=2286 and v'=1045.
- Pulse start at cycles 5, 40 and 72 of a running pass: the pass is not restarted, there is only one done, and the write count is exactly 64.
- Assert rst at cycle 20: every output is 0 in the same cycle, and there are no wr_en pulses afterwards. A new start after reset completes a full clean pass.
- Run with N_PAIRS=1: rd_en in cycle 1, wr_en in cycle 8 with addresses 0 and 1, and done in cycle 9.

Source files
------------

// File: rtl/pe3_pkg.sv
// Shared constants and state type for the PE3 pass sequencer.
// Twiddle values document what sel selects inside PE3.
package pe3_pkg;

  localparam int unsigned PE3_LAT    = 6;
  localparam int unsigned RAM_RD_LAT = 1;
  localparam int unsigned TW_SEL0    = 2285;
  localparam int unsigned TW_SEL1    = 3095;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } pe3_state_e;

endpackage

// File: rtl/pe3_delay_line.sv
// Fixed-depth shift register with asynchronous active-high clear.
// Used to track in-flight entries through the RAM read and PE3 pipeline.
module pe3_delay_line #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Depth-1:0][Width-1:0] stage_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/pe3_seq.sv
// Sequencer for one pass of PE3 butterflies over an in-place coefficient RAM:
// issues paired reads, aligns the twiddle select and writes results back.
module pe3_seq
  import pe3_pkg::*;
#(
  parameter int unsigned data_width = 12,
  parameter int unsigned addr_width = 7,
  parameter int unsigned N_PAIRS    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [addr_width-1:0] rd_addr_u,
  output logic [addr_width-1:0] rd_addr_v,
  output logic                  sel,
  output logic                  wr_en,
  output logic [addr_width-1:0] wr_addr_u,
  output logic [addr_width-1:0] wr_addr_v
);

  if (N_PAIRS < 1 || N_PAIRS > (1 << (addr_width - 1)) || data_width < 1) begin : g_param_check
    $error("pe3_seq: illegal parameter combination");
  end

  localparam int unsigned DlyDepth = RAM_RD_LAT + PE3_LAT;
  localparam int unsigned DlyWidth = 1 + 2 * addr_width;
  localparam int unsigned CntW     = $clog2(DlyDepth + 1);

  localparam logic [addr_width-1:0] NPairs = addr_width'(N_PAIRS);
  localparam logic [addr_width-1:0] LastJ  = addr_width'(N_PAIRS - 1);
  localparam logic [addr_width-1:0] HalfJ  = addr_width'(N_PAIRS / 2);

  pe3_state_e            state_q, state_d;
  logic [addr_width-1:0] j_q, j_d;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic                  pending;
  logic                  sel_raw;
  logic [DlyWidth-1:0]   dly_d, dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      j_q        <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      inflight_q <= inflight_d;
    end
  end

  // Entries still in the delay line after this edge; rd_en is low while draining.
  assign inflight_d = inflight_q + CntW'(rd_en) - CntW'(wr_en);
  assign pending    = (inflight_q != CntW'(wr_en));

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          j_d     = '0;
        end
      end
      StIssue: begin
        j_d = j_q + 1'b1;
        if (j_q == LastJ) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!pending) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en     = (state_q == StIssue);
    busy      = (state_q == StIssue) || (state_q == StDrain);
    done      = (state_q == StDone);
    rd_addr_u = rd_en ? j_q : '0;
    rd_addr_v = rd_en ? (j_q + NPairs) : '0;
    sel_raw   = rd_en && (j_q >= HalfJ);
  end

  // Idle slots carry zero addresses so the write side rests at zero.
  assign dly_d = {rd_en, rd_addr_u, rd_addr_v};

  pe3_delay_line #(
    .Depth(DlyDepth),
    .Width(DlyWidth)
  ) u_addr_dly (
    .clk_i(clk),
    .clr_i(rst),
    .d_i  (dly_d),
    .q_o  (dly_q)
  );

  assign {wr_en, wr_addr_u, wr_addr_v} = dly_q;

  pe3_delay_line #(
    .Depth(RAM_RD_LAT),
    .Width(1)
  ) u_sel_dly (
    .clk_i(clk),
    .clr_i(rst),
    .d_i  (sel_raw),
    .q_o  (sel)
  );

endmodule

// File: tb/tb_pe3_seq.sv
// Directed bench for pe3_seq: cycle-accurate vector table plus RAM/PE3 model.
module tb_pe3_seq;
  import pe3_pkg::*;

  localparam int unsigned AW = 7;
  localparam int Q = 3329;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic mem_init = 1'b0;

  logic busy, done, rd_en, sel, wr_en;
  logic [AW-1:0] rd_u, rd_v, wr_u, wr_v;
  logic busy1, done1, rd_en1, sel1, wr_en1;
  logic [AW-1:0] rd_u1, rd_v1, wr_u1, wr_v1;

  always #5 clk = ~clk;

  pe3_seq #(.data_width(12), .addr_width(AW), .N_PAIRS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_u(rd_u), .rd_addr_v(rd_v), .sel(sel),
    .wr_en(wr_en), .wr_addr_u(wr_u), .wr_addr_v(wr_v)
  );

  pe3_seq #(.data_width(12), .addr_width(AW), .N_PAIRS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr_u(rd_u1), .rd_addr_v(rd_v1), .sel(sel1),
    .wr_en(wr_en1), .wr_addr_u(wr_u1), .wr_addr_v(wr_v1)
  );

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] rd_u;
    logic [AW-1:0] rd_v;
    logic          sel;
    logic          wr_en;
    logic [AW-1:0] wr_u;
    logic [AW-1:0] wr_v;
    logic          busy;
    logic          done;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  int   nvec = 0;
  int   nerr = 0;
  obs_t tr [0:99];

  // ---------------- golden butterfly and RAM/PE3 model ----------------
  function automatic logic [11:0] bf_u(input int u, input int v, input logic s);
    int w = s ? int'(TW_SEL1) : int'(TW_SEL0);
    return 12'((u + (v * w) % Q) % Q);
  endfunction

  function automatic logic [11:0] bf_v(input int u, input int v, input logic s);
    int w = s ? int'(TW_SEL1) : int'(TW_SEL0);
    return 12'((u + Q - (v * w) % Q) % Q);
  endfunction

  function automatic int init_val(input int i);
    if (i == 0 || i == 64) return 1;
    return (i * 37 + 5) % Q;
  endfunction

  logic [11:0] mem [0:127];
  logic [11:0] ud = '0, vd = '0;
  logic        rdv = 1'b0;
  logic [11:0] pu [0:5];
  logic [11:0] pv [0:5];
  logic        pval [0:5] = '{default: 1'b0};
  int          align_err = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 12'(init_val(i));
    end else if (wr_en) begin
      mem[wr_u] <= pu[5];
      mem[wr_v] <= pv[5];
    end
    if (rd_en) begin
      ud <= mem[rd_u];
      vd <= mem[rd_v];
    end
    rdv     <= rd_en & ~rst;
    pval[0] <= rdv & ~rst;
    pu[0]   <= bf_u(int'(ud), int'(vd), sel);
    pv[0]   <= bf_v(int'(ud), int'(vd), sel);
    for (int i = 1; i < 6; i++) begin
      pval[i] <= pval[i-1] & ~rst;
      pu[i]   <= pu[i-1];
      pv[i]   <= pv[i-1];
    end
    if (!rst && (wr_en !== pval[5])) align_err++;
  end

  // ---------------- helpers ----------------
  function automatic obs_t ob(input logic re, input int ru, input int rv, input logic s,
                              input logic we, input int wu, input int wv,
                              input logic b, input logic d);
    obs_t o;
    o.rd_en = re;  o.rd_u = 7'(ru);  o.rd_v = 7'(rv);  o.sel = s;
    o.wr_en = we;  o.wr_u = 7'(wu);  o.wr_v = 7'(wv);  o.busy = b;  o.done = d;
    return o;
  endfunction

  function automatic obs_t sample0();
    return ob(rd_en, int'(rd_u), int'(rd_v), sel, wr_en, int'(wr_u), int'(wr_v), busy, done);
  endfunction

  function automatic obs_t sample1();
    return ob(rd_en1, int'(rd_u1), int'(rd_v1), sel1, wr_en1, int'(wr_u1), int'(wr_v1),
              busy1, done1);
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got rd=%b u=%0d v=%0d sel=%b wr=%b u=%0d v=%0d busy=%b done=%b; want rd=%b u=%0d v=%0d sel=%b wr=%b u=%0d v=%0d busy=%b done=%b",
               name, act.rd_en, act.rd_u, act.rd_v, act.sel, act.wr_en, act.wr_u, act.wr_v,
               act.busy, act.done, exp.rd_en, exp.rd_u, exp.rd_v, exp.sel, exp.wr_en,
               exp.wr_u, exp.wr_v, exp.busy, exp.done);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Pass start at negedge; tr[k] is the sample in cycle k after the accepting edge.
  task automatic run_pass(input int p1, input int p2, input int p3, input int ncyc);
    @(negedge clk);
    tr[0] = sample0();
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = (k == p1) || (k == p2) || (k == p3);
      tr[k] = sample0();
    end
    start = 1'b0;
  endtask

  function automatic int count_bit(input int which, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) begin
      case (which)
        0: n += int'(tr[k].rd_en);
        1: n += int'(tr[k].wr_en);
        2: n += int'(tr[k].done);
        default: n += int'(tr[k].busy);
      endcase
    end
    return n;
  endfunction

  // ---------------- test ----------------
  vec_t vecs [13];
  int   errs;

  initial begin
    vecs[0]  = '{0,  ob(0, 0, 0,   0, 0, 0, 0,    0, 0)};
    vecs[1]  = '{1,  ob(1, 0, 64,  0, 0, 0, 0,    1, 0)};
    vecs[2]  = '{2,  ob(1, 1, 65,  0, 0, 0, 0,    1, 0)};
    vecs[3]  = '{7,  ob(1, 6, 70,  0, 0, 0, 0,    1, 0)};
    vecs[4]  = '{8,  ob(1, 7, 71,  0, 1, 0, 64,   1, 0)};
    vecs[5]  = '{33, ob(1, 32, 96, 0, 1, 25, 89,  1, 0)};
    vecs[6]  = '{34, ob(1, 33, 97, 1, 1, 26, 90,  1, 0)};
    vecs[7]  = '{64, ob(1, 63, 127, 1, 1, 56, 120, 1, 0)};
    vecs[8]  = '{65, ob(0, 0, 0,   1, 1, 57, 121, 1, 0)};
    vecs[9]  = '{66, ob(0, 0, 0,   0, 1, 58, 122, 1, 0)};
    vecs[10] = '{71, ob(0, 0, 0,   0, 1, 63, 127, 1, 0)};
    vecs[11] = '{72, ob(0, 0, 0,   0, 0, 0, 0,    0, 1)};
    vecs[12] = '{73, ob(0, 0, 0,   0, 0, 0, 0,    0, 0)};

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_obs("reset_state", sample0(), '0);
    check_obs("reset_state_n1", sample1(), '0);
    rst = 1'b0;
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;

    // Main pass, N_PAIRS=64
    run_pass(-1, -1, -1, 75);
    foreach (vecs[i]) check_obs($sformatf("pass_cyc%0d", vecs[i].cyc), tr[vecs[i].cyc], vecs[i].exp);
    check_int("rd_count", count_bit(0, 0, 75), 64);
    check_int("wr_count", count_bit(1, 0, 75), 64);
    check_int("done_count", count_bit(2, 0, 75), 1);
    check_int("busy_count", count_bit(3, 0, 75), 71);
    errs = 0;
    for (int k = 1; k <= 64; k++)
      if (tr[k].rd_u != 7'(k - 1) || tr[k].rd_v != 7'(k + 63)) errs++;
    check_int("rd_addr_seq", errs, 0);
    errs = 0;
    for (int k = 8; k <= 71; k++)
      if (!tr[k].wr_en || tr[k].wr_u != 7'(k - 8) || tr[k].wr_v != 7'(k + 56)) errs++;
    check_int("wr_addr_seq", errs, 0);
    errs = 0;
    for (int k = 2; k <= 65; k++)
      if (tr[k].sel !== (k >= 34)) errs++;
    check_int("sel_align", errs, 0);

    // End-to-end memory contents against golden butterflies
    check_int("e2e_sample_u", int'(mem[0]), 2286);
    check_int("e2e_sample_v", int'(mem[64]), 1045);
    errs = 0;
    for (int j = 0; j < 64; j++) begin
      if (mem[j] !== bf_u(init_val(j), init_val(j + 64), j >= 32)) errs++;
      if (mem[j + 64] !== bf_v(init_val(j), init_val(j + 64), j >= 32)) errs++;
    end
    check_int("e2e_mem", errs, 0);

    // start pulses during a running pass and in the done cycle are ignored
    run_pass(5, 40, 72, 85);
    check_int("restart_rd_count", count_bit(0, 0, 85), 64);
    check_int("restart_wr_count", count_bit(1, 0, 85), 64);
    check_int("restart_done_count", count_bit(2, 0, 85), 1);
    check_int("restart_done_cyc", int'(tr[72].done), 1);

    // Asynchronous reset mid-pass
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1 check_obs("rst_mid_outputs", sample0(), '0);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (wr_en || rd_en || busy || done) errs++;
    end
    check_int("rst_no_activity", errs, 0);
    run_pass(-1, -1, -1, 75);
    check_int("post_rst_wr_count", count_bit(1, 0, 75), 64);
    check_obs("post_rst_cyc8", tr[8], vecs[4].exp);
    check_obs("post_rst_cyc72", tr[72], vecs[11].exp);

    // N_PAIRS=1 instance
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      tr[k] = sample1();
    end
    check_obs("n1_cyc1", tr[1], ob(1, 0, 1, 0, 0, 0, 0, 1, 0));
    check_obs("n1_cyc2", tr[2], ob(0, 0, 0, 1, 0, 0, 0, 1, 0));
    check_obs("n1_cyc8", tr[8], ob(0, 0, 0, 0, 1, 0, 1, 1, 0));
    check_obs("n1_cyc9", tr[9], ob(0, 0, 0, 0, 0, 0, 0, 0, 1));
    check_obs("n1_cyc10", tr[10], '0);
    check_int("n1_rd_count", count_bit(0, 1, 12), 1);
    check_int("n1_wr_count", count_bit(1, 1, 12), 1);

    check_int("pipe_alignment", align_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
